// File: rtl/bin_search_pkg.sv
// Shared types and defaults for the binary-search comparator initiator.
package bin_search_pkg;

  localparam int unsigned W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    WAIT = ST_WAIT,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/bs_window.sv
// Search window: lo/hi bounds, midpoint and exhaustion detection.
// Bounds are W+1 bits; hi is read as signed (may reach -1), lo as unsigned (may reach 2^W).
module bs_window
  import bin_search_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         upd_lo,
  input  logic         upd_hi,
  input  logic [W-1:0] guess,
  output logic [W-1:0] mid,
  output logic         empty
);

  localparam int unsigned WW = W + 1;

  logic [W:0] lo;
  logic [W:0] hi;
  logic [W:0] lo_n;
  logic [W:0] hi_n;

  // Next-state bounds, also used so the FSM can end the search on the update edge
  always_comb begin
    lo_n = lo;
    hi_n = hi;
    if (init) begin
      lo_n = '0;
      hi_n = {1'b0, {W{1'b1}}};
    end else begin
      if (upd_lo) lo_n = {1'b0, guess} + WW'(1);
      if (upd_hi) hi_n = {1'b0, guess} - WW'(1);
    end
  end

  // Negative hi (top bit set) always means an empty window
  assign empty = hi_n[W] | (lo_n > hi_n);

  assign mid = W'((lo + hi) >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      lo <= '0;
      hi <= {1'b0, {W{1'b1}}};
    end else begin
      lo <= lo_n;
      hi <= hi_n;
    end
  end

endmodule

// File: rtl/bin_search_ctrl.sv
// Binary-search initiator: probes a comparator with guesses until eq or window exhaustion.
module bin_search_ctrl
  import bin_search_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         cmp_req,
  output logic [W-1:0] guess,
  input  logic         cmp_ack,
  input  logic         cmp_eq,
  input  logic         cmp_gt,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         err,
  output logic [W-1:0] result,
  output logic [W-1:0] probes
);

  state_t       state;
  logic         ack_hit;
  logic         win_init;
  logic         win_upd_lo;
  logic         win_upd_hi;
  logic [W-1:0] win_mid;
  logic         win_empty;

  assign ack_hit    = (state == WAIT) & cmp_req & cmp_ack;
  assign win_init   = (state == IDLE) & start;
  assign win_upd_hi = ack_hit & ~cmp_eq & cmp_gt;
  assign win_upd_lo = ack_hit & ~cmp_eq & ~cmp_gt;

  bs_window #(
    .W(W)
  ) u_window (
    .clk   (clk),
    .reset (reset),
    .init  (win_init),
    .upd_lo(win_upd_lo),
    .upd_hi(win_upd_hi),
    .guess (guess),
    .mid   (win_mid),
    .empty (win_empty)
  );

  // Control FSM with registered outputs; done is high exactly while in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cmp_req <= 1'b0;
      guess   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      found   <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      probes  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            probes <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          guess   <= win_mid;
          cmp_req <= 1'b1;
          state   <= WAIT;
        end
        WAIT: begin
          if (ack_hit) begin
            cmp_req <= 1'b0;
            probes  <= probes + W'(1);
            if (cmp_eq && cmp_gt) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else if (cmp_eq) begin
              found  <= 1'b1;
              result <= guess;
              done   <= 1'b1;
              state  <= DONE;
            end else if (win_empty) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_search_ctrl.sv
// Directed bench for bin_search_ctrl with a programmable comparator responder.
module tb_bin_search_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       cmp_req;
  logic [7:0] guess;
  logic       cmp_ack;
  logic       cmp_eq;
  logic       cmp_gt;
  logic       busy;
  logic       done;
  logic       found;
  logic       err;
  logic [7:0] result;
  logic [7:0] probes;

  // responder configuration: 0 normal, 1 never eq/gt, 2 always gt, 3 eq&gt at guess 63
  logic [7:0] target;
  int         mode;
  int         ack_dly;
  int         wait_cnt;
  logic [1:0] noise;

  int total;
  int bad;
  int unsigned exp_g[$];
  int unsigned glog[$];

  bin_search_ctrl #(.W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .cmp_req(cmp_req),
    .guess  (guess),
    .cmp_ack(cmp_ack),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result),
    .probes (probes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    noise <= 2'($urandom);
    if (cmp_req && !cmp_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  always_comb begin
    cmp_ack = cmp_req && (wait_cnt >= ack_dly);
    cmp_eq  = noise[0];
    cmp_gt  = noise[1];
    if (cmp_ack) begin
      case (mode)
        1: begin cmp_eq = 1'b0; cmp_gt = 1'b0; end
        2: begin cmp_eq = 1'b0; cmp_gt = 1'b1; end
        3: begin
          cmp_eq = (guess == target) || (guess == 8'd63);
          cmp_gt = (guess > target) || (guess == 8'd63);
        end
        default: begin
          cmp_eq = (guess == target);
          cmp_gt = (guess > target);
        end
      endcase
    end
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_search(input string nm, input int tgt, input int md, input int dly,
                            input bit poke, input int e_found, input int e_err,
                            input int e_res, input int e_probes, input int e_lat);
    bit          got;
    bit          prev_wait;
    logic [7:0]  prev_guess;
    int          stab_bad;
    int          dcnt;
    int          lat;
    target  = 8'(tgt);
    mode    = md;
    ack_dly = dly;
    glog.delete();
    stab_bad   = 0;
    dcnt       = 0;
    lat        = -1;
    got        = 1'b0;
    prev_wait  = 1'b0;
    prev_guess = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      if (poke) start = (c >= 2 && c < 6);
      if (cmp_req && cmp_ack) glog.push_back(int'(guess));
      if (prev_wait && cmp_req && guess != prev_guess) stab_bad++;
      prev_wait  = cmp_req && !cmp_ack;
      prev_guess = guess;
      if (done) begin
        dcnt++;
        got = 1'b1;
        lat = c;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!got) chk({nm, "/timeout"}, 0, 1);
    chk({nm, "/found"}, int'(found), e_found);
    chk({nm, "/err"}, int'(err), e_err);
    chk({nm, "/result"}, int'(result), e_res);
    chk({nm, "/probes"}, int'(probes), e_probes);
    chk({nm, "/busy_in_done"}, int'(busy), 1);
    chk({nm, "/nguess"}, glog.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < glog.size(); i++)
      chk($sformatf("%s/guess%0d", nm, i), glog[i], exp_g[i]);
    chk({nm, "/stable"}, stab_bad, 0);
    if (e_lat >= 0) chk({nm, "/latency"}, lat, e_lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk({nm, "/done_pulses"}, dcnt, 1);
    chk({nm, "/busy_after"}, int'(busy), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "/req"}, int'(cmp_req), 0);
    chk({nm, "/guess"}, int'(guess), 0);
    chk({nm, "/busy"}, int'(busy), 0);
    chk({nm, "/done"}, int'(done), 0);
    chk({nm, "/found"}, int'(found), 0);
    chk({nm, "/err"}, int'(err), 0);
    chk({nm, "/result"}, int'(result), 0);
    chk({nm, "/probes"}, int'(probes), 0);
  endtask

  initial begin
    int dcnt;
    bit seen;
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    start   = 1'b0;
    target  = '0;
    mode    = 0;
    ack_dly = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    exp_g = '{127};
    run_search("hit127", 127, 0, 0, 1'b0, 1, 0, 127, 1, 2);

    exp_g = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    run_search("t255", 255, 0, 0, 1'b0, 1, 0, 255, 9, -1);

    exp_g = '{127, 63, 31, 15, 7, 3, 1, 0};
    run_search("t0", 0, 0, 0, 1'b0, 1, 0, 0, 8, -1);

    exp_g = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    run_search("neither", 0, 1, 0, 1'b0, 0, 0, 0, 9, -1);

    exp_g = '{127, 63, 31, 15, 7, 3, 1, 0};
    run_search("always_gt", 0, 2, 0, 1'b0, 0, 0, 0, 8, -1);

    exp_g = '{127, 191, 223, 207, 199, 203, 201, 200};
    run_search("slow200", 200, 0, 3, 1'b0, 1, 0, 200, 8, -1);

    exp_g = '{127, 63};
    run_search("proto_err", 50, 3, 0, 1'b0, 0, 1, 0, 2, -1);

    exp_g = '{127};
    run_search("err_clear", 127, 0, 0, 1'b0, 1, 0, 127, 1, -1);

    exp_g = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    run_search("start_busy", 255, 0, 0, 1'b1, 1, 0, 255, 9, -1);

    // reset while a probe is outstanding
    target  = 8'd200;
    mode    = 0;
    ack_dly = 3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (cmp_req) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rst_wait/req_seen", int'(seen), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero("rst_wait");
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("rst_wait/no_done", dcnt, 0);
    chk("rst_wait/idle_req", int'(cmp_req), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
